display_source_scheduler: RTL and testbench

- Time-shares the 4-digit hex seven-segment display between NUM_SRC requesters, e.g. pattern counter, error code and status word.
- Round-robin scheduling: each granted value is latched and held for DWELL_CYCLES.
- A priority override input preempts the rotation.
- Generates the digit-scan clock-enable strobe.
- Sits between the pattern generator's status sources and the seven_segment_display decoder. num_out drives that decoder's num_in; scan_en gates its clock enable.

---
 rtl/display_pkg.sv | 45 ++++
 rtl/strobe_divider.sv | 30 +++
 rtl/display_source_scheduler.sv | 152 +++++++++++++++
 tb/tb_display_source_scheduler.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// display_pkg: definitions shared by the display source scheduler and the
// seven-segment decoder.
//   NUM_W / DIGIT_W : displayed word width and nibble-per-digit width
//   SEL_NONE        : src_sel code meaning "override or nothing shown"
//   ST_*            : scheduler FSM state encodings
//   hex_glyph()     : nibble -> segment pattern {g,f,e,d,c,b,a}, active high
package display_pkg;

  localparam int NUM_W   = 16;
  localparam int DIGIT_W = 4;

  localparam logic [2:0] SEL_NONE = 3'd7;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_LOAD     = 2'd1;
  localparam state_t ST_SHOW     = 2'd2;
  localparam state_t ST_OVERRIDE = 2'd3;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] hex_glyph(input logic [DIGIT_W-1:0] d);
    logic [6:0] g;
    case (d)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/strobe_divider.sv
// strobe_divider: free-running 0..DIV-1 counter producing a registered
// one-cycle clock-enable pulse each time the counter wraps. The first pulse
// appears DIV cycles after reset release.
//   clk    : clock
//   rst    : asynchronous active-high reset
//   en_out : one-cycle enable strobe
module strobe_divider #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic en_out
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      en_out <= 1'b0;
    end else begin
      en_out <= (cnt == CNT_LAST);
      cnt    <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/display_source_scheduler.sv
// display_source_scheduler: time-shares the 4-digit hex display between
// NUM_SRC requesters with round-robin grants held for DWELL_CYCLES, a live
// priority override, and the digit-scan enable strobe.
//   clk, rst   : clock, asynchronous active-high reset
//   src_valid  : per-source request level
//   src_data   : per-source 16-bit value, source i at [16*i+15:16*i]
//   src_ack    : one-cycle pulse in the LOAD cycle that latches a source
//   pri_valid  : override request level; pri_data shown live while high
//   num_out    : value for the decoder
//   src_sel    : index of displayed source, 7 = override/none
//   blank      : decoder must blank all digits
//   scan_en    : one-cycle digit-scan clock enable
// All outputs are registered.
module display_source_scheduler
  import display_pkg::*;
#(
  parameter int NUM_SRC      = 4,
  parameter int DWELL_CYCLES = 50000000,
  parameter int SCAN_DIV     = 50000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SRC-1:0]       src_valid,
  input  logic [16*NUM_SRC-1:0]    src_data,
  output logic [NUM_SRC-1:0]       src_ack,
  input  logic                     pri_valid,
  input  logic [15:0]              pri_data,
  output logic [15:0]              num_out,
  output logic [2:0]               src_sel,
  output logic                     blank,
  output logic                     scan_en
);

  localparam int IDX_W = $clog2(NUM_SRC);
  localparam int DW    = $clog2(DWELL_CYCLES);
  localparam logic [IDX_W-1:0]   LAST_RST   = IDX_W'(NUM_SRC - 1);
  localparam logic [DW-1:0]      DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [NUM_SRC-1:0] ONE        = NUM_SRC'(1);

  state_t           state;
  logic [IDX_W-1:0] last;      // rr pointer: most recently loaded source
  logic [IDX_W-1:0] grant;     // source acked on the way into LOAD
  logic [DW-1:0]    dwell;
  logic [IDX_W-1:0] pick;
  logic [IDX_W-1:0] load_idx;
  logic             any_valid;

  // First set bit searching upward from ptr+1 with wrap; ptr itself is the
  // lowest-priority candidate. Caller qualifies with any_valid.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_SRC-1:0] v,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] res;
    int               idx;
    res = ptr;
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx = (int'(ptr) + k) % NUM_SRC;
      if (v[idx]) res = IDX_W'(idx);
    end
    return res;
  endfunction

  assign any_valid = |src_valid;
  assign pick      = rr_pick(src_valid, last);
  // Keep the acked grant unless it dropped its request meanwhile; then
  // re-arbitrate on the current requests.
  assign load_idx  = src_valid[grant] ? grant : pick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      num_out <= '0;
      src_sel <= SEL_NONE;
      blank   <= 1'b1;
      src_ack <= '0;
      dwell   <= '0;
      last    <= LAST_RST;
      grant   <= LAST_RST;
    end else begin
      src_ack <= '0;
      case (state)
        ST_IDLE: begin
          if (pri_valid) begin
            state   <= ST_OVERRIDE;
            num_out <= pri_data;
            src_sel <= SEL_NONE;
            blank   <= 1'b0;
          end else if (any_valid) begin
            // Ack is registered on entry so it is high during LOAD itself.
            state   <= ST_LOAD;
            src_ack <= ONE << pick;
            grant   <= pick;
          end
        end
        ST_LOAD: begin
          // pri_valid deliberately not looked at here; it takes effect in SHOW.
          if (any_valid) begin
            state   <= ST_SHOW;
            num_out <= src_data[NUM_W*int'(load_idx) +: NUM_W];
            src_sel <= 3'(load_idx);
            blank   <= 1'b0;
            last    <= load_idx;
            dwell   <= '0;
          end else begin
            state   <= ST_IDLE;
            src_sel <= SEL_NONE;
            blank   <= 1'b1;
          end
        end
        ST_SHOW: begin
          if (pri_valid) begin
            state   <= ST_OVERRIDE;
            num_out <= pri_data;
            src_sel <= SEL_NONE;
            blank   <= 1'b0;
          end else if (dwell == DWELL_LAST) begin
            if (any_valid) begin
              state   <= ST_LOAD;
              src_ack <= ONE << pick;
              grant   <= pick;
            end else begin
              state   <= ST_IDLE;
              src_sel <= SEL_NONE;
              blank   <= 1'b1;
            end
          end else begin
            dwell <= dwell + 1'b1;
          end
        end
        default: begin // ST_OVERRIDE: dwell frozen, preempted dwell abandoned
          if (pri_valid) begin
            num_out <= pri_data;
          end else if (any_valid) begin
            state   <= ST_LOAD;
            src_ack <= ONE << pick;
            grant   <= pick;
          end else begin
            state   <= ST_IDLE;
            src_sel <= SEL_NONE;
            blank   <= 1'b1;
          end
        end
      endcase
    end
  end

  strobe_divider #(.DIV(SCAN_DIV)) u_scan (
    .clk    (clk),
    .rst    (rst),
    .en_out (scan_en)
  );

endmodule

// File: tb/tb_display_source_scheduler.sv
// Scoreboard bench: stimulus pushes expected (cycle, signal, value) records;
// the negedge monitor compares every record due in the current cycle.
module tb_display_source_scheduler;

  localparam int K_NUM = 0, K_SEL = 1, K_BLANK = 2, K_ACK = 3, K_SCAN = 4;

  typedef struct {
    int          cyc;
    int          kind;
    logic [15:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  src_valid;
  logic [63:0] src_data;
  logic [3:0]  src_ack;
  logic        pri_valid;
  logic [15:0] pri_data;
  logic [15:0] num_out;
  logic [2:0]  src_sel;
  logic        blank;
  logic        scan_en;

  exp_t        sb[$];
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  logic        done = 1'b0;
  logic [15:0] rot_val [4];
  logic [15:0] rot_sel [4];

  display_source_scheduler #(.NUM_SRC(4), .DWELL_CYCLES(8), .SCAN_DIV(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_ack   (src_ack),
    .pri_valid (pri_valid),
    .pri_data  (pri_data),
    .num_out   (num_out),
    .src_sel   (src_sel),
    .blank     (blank),
    .scan_en   (scan_en)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] actual(input int kind);
    case (kind)
      K_NUM:   return num_out;
      K_SEL:   return {13'd0, src_sel};
      K_BLANK: return {15'd0, blank};
      K_ACK:   return {12'd0, src_ack};
      default: return {15'd0, scan_en};
    endcase
  endfunction

  function automatic string kname(input int kind);
    case (kind)
      K_NUM:   return "num_out";
      K_SEL:   return "src_sel";
      K_BLANK: return "blank";
      K_ACK:   return "src_ack";
      default: return "scan_en";
    endcase
  endfunction

  // Monitor: compare every record due this cycle, then finish when told.
  always @(negedge clk) begin
    logic [15:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        act = actual(sb[i].kind);
        vectors++;
        if (act !== sb[i].val) begin
          miscompares++;
          $display("FAIL %s @cycle %0d: got %h, expected %h", kname(sb[i].kind), cyc, act, sb[i].val);
        end
        sb.delete(i);
      end
    end
    if (done) begin
      for (int i = 0; i < sb.size(); i++) begin
        miscompares++;
        $display("FAIL %s @cycle %0d never checked: got -, expected %h", kname(sb[i].kind), sb[i].cyc, sb[i].val);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic want(input int c, input int kind, input logic [15:0] v);
    exp_t e;
    e.cyc = c; e.kind = kind; e.val = v;
    sb.push_back(e);
  endtask

  initial begin
    int b;
    rst = 1'b1; src_valid = '0; src_data = '0; pri_valid = 1'b0; pri_data = '0;
    rot_val[0] = 16'h1111; rot_val[1] = 16'h2222; rot_val[2] = 16'h4444; rot_val[3] = 16'h1111;
    rot_sel[0] = 16'd0;    rot_sel[1] = 16'd1;    rot_sel[2] = 16'd3;    rot_sel[3] = 16'd0;

    // Reset values and scan strobe at 4, 8, 12 after release
    step(3);
    b = cyc;
    want(b, K_NUM, 16'h0); want(b, K_SEL, 16'd7); want(b, K_BLANK, 16'd1);
    want(b, K_ACK, 16'd0); want(b, K_SCAN, 16'd0);
    for (int c = 1; c <= 13; c++) want(b + c, K_SCAN, (c % 4 == 0) ? 16'd1 : 16'd0);
    #2 rst = 1'b0;
    step(14);

    // Rotation 1011 from reset pointer: 1111, 2222, 4444, 1111; src 2 skipped
    src_data  = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    src_valid = 4'b1011;
    b = cyc;
    for (int c = 1; c <= 29; c++)
      want(b + c, K_ACK, (c == 1 || c == 28) ? 16'h1 : (c == 10) ? 16'h2 : (c == 19) ? 16'h8 : 16'h0);
    for (int c = 2; c <= 30; c++) begin
      want(b + c, K_NUM, rot_val[(c - 2) / 9]);
      want(b + c, K_SEL, rot_sel[(c - 2) / 9]);
    end
    want(b + 36, K_BLANK, 16'd0);
    want(b + 37, K_BLANK, 16'd1); want(b + 37, K_SEL, 16'd7);
    step(30);
    src_valid = 4'b0000;
    step(10);

    // Override at dwell 3 of src 1; live pri_data; release grants src 3
    src_valid = 4'b1010;
    b = cyc;
    want(b + 1, K_ACK, 16'h2);
    for (int c = 2; c <= 5; c++) begin want(b + c, K_NUM, 16'h2222); want(b + c, K_SEL, 16'd1); end
    for (int c = 6; c <= 11; c++) begin
      want(b + c, K_NUM, (c <= 8) ? 16'hBEEF : 16'hBEE0);
      want(b + c, K_SEL, 16'd7);
      want(b + c, K_BLANK, 16'd0);
    end
    for (int c = 6; c <= 10; c++) want(b + c, K_ACK, 16'h0);
    want(b + 11, K_ACK, 16'h8);
    want(b + 12, K_NUM, 16'h4444); want(b + 12, K_SEL, 16'd3);
    want(b + 20, K_BLANK, 16'd1);
    step(5);
    pri_valid = 1'b1; pri_data = 16'hBEEF;
    step(3);
    pri_data = 16'hBEE0;
    step(2);
    pri_valid = 1'b0;
    step(2);
    src_valid = 4'b0000;
    step(10);

    // Drop during dwell: full dwell kept, then IDLE with value held
    src_data  = {16'h4444, 16'h3333, 16'h2222, 16'h1234};
    src_valid = 4'b0001;
    b = cyc;
    want(b + 1, K_ACK, 16'h1);
    for (int c = 2; c <= 12; c++) begin
      want(b + c, K_NUM, 16'h1234);
      want(b + c, K_ACK, 16'h0);
      want(b + c, K_BLANK, (c >= 10) ? 16'd1 : 16'd0);
    end
    want(b + 9, K_SEL, 16'd0); want(b + 10, K_SEL, 16'd7);
    step(4);
    src_valid = 4'b0000;
    step(10);

    // Single source re-granted every 9 cycles
    src_valid = 4'b0001;
    b = cyc;
    for (int c = 1; c <= 20; c++) want(b + c, K_ACK, ((c - 1) % 9 == 0) ? 16'h1 : 16'h0);
    for (int c = 2; c <= 20; c++) begin
      want(b + c, K_NUM, 16'h1234); want(b + c, K_SEL, 16'd0); want(b + c, K_BLANK, 16'd0);
    end
    step(20);
    src_valid = 4'b0000;
    step(10);

    // Async reset mid-SHOW, no clock edge while asserted
    src_valid = 4'b0010;
    b = cyc;
    want(b + 1, K_ACK, 16'h2);
    want(b + 3, K_NUM, 16'h2222); want(b + 3, K_SEL, 16'd1);
    want(b + 4, K_NUM, 16'h0); want(b + 4, K_SEL, 16'd7); want(b + 4, K_BLANK, 16'd1);
    want(b + 4, K_ACK, 16'h0); want(b + 4, K_SCAN, 16'd0);
    want(b + 5, K_ACK, 16'h1);
    want(b + 6, K_NUM, 16'h1234); want(b + 6, K_SEL, 16'd0); want(b + 6, K_BLANK, 16'd0);
    for (int c = 5; c <= 8; c++) want(b + c, K_SCAN, (c == 8) ? 16'd1 : 16'd0);
    step(4);
    src_valid = 4'b0011;
    #1 rst = 1'b1;
    #5 rst = 1'b0;
    step(6);
    done = 1'b1;
  end

endmodule
